// File: rtl/mem_stage.sv
// Memory stage of the RV32 pipeline. ALU and AUIPC results pass through in one cycle.
// LW and SW go through a request/ready handshake with a timeout, and the stage stalls execute meanwhile.
module mem_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [6:0]  ex_opcode,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign_err,
  output logic        bus_err
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state_q, state_d;
  logic        dmem_req_q, dmem_req_d;
  logic        dmem_we_q, dmem_we_d;
  logic [31:0] dmem_addr_q, dmem_addr_d;
  logic [31:0] dmem_wdata_q, dmem_wdata_d;
  logic [4:0]  rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        wb_valid_q, wb_valid_d;
  logic        wb_reg_write_q, wb_reg_write_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        misalign_q, misalign_d;
  logic        bus_err_q, bus_err_d;

  always_comb begin
    state_d        = state_q;
    dmem_req_d     = dmem_req_q;
    dmem_we_d      = dmem_we_q;
    dmem_addr_d    = dmem_addr_q;
    dmem_wdata_d   = dmem_wdata_q;
    rd_d           = rd_q;
    cnt_d          = cnt_q;
    wb_valid_d     = 1'b0;
    wb_reg_write_d = 1'b0;
    wb_rd_d        = wb_rd_q;
    wb_data_d      = wb_data_q;
    misalign_d     = 1'b0;
    bus_err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (ex_valid) begin
          case (ex_opcode)
            OP_R, OP_I, OP_AUIPC: begin
              wb_valid_d     = 1'b1;
              wb_data_d      = ex_alu_result;
              wb_rd_d        = ex_rd;
              wb_reg_write_d = (ex_rd != 5'd0);
            end
            OP_LW, OP_SW: begin
              if (ex_alu_result[1:0] != 2'b00) begin
                wb_valid_d = 1'b1;
                misalign_d = 1'b1;
              end else begin
                dmem_req_d   = 1'b1;
                dmem_we_d    = (ex_opcode == OP_SW);
                dmem_addr_d  = ex_alu_result;
                dmem_wdata_d = ex_store_data;
                rd_d         = ex_rd;
                cnt_d        = '0;
                state_d      = ACCESS;
              end
            end
            default: ;
          endcase
        end
      end
      ACCESS: begin
        // Ready takes priority over an expiring timeout in the same cycle.
        if (dmem_ready) begin
          dmem_req_d = 1'b0;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          state_d    = IDLE;
          if (!dmem_we_q) begin
            wb_data_d      = dmem_rdata;
            wb_reg_write_d = (rd_q != 5'd0);
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          dmem_req_d = 1'b0;
          bus_err_d  = 1'b1;
          wb_valid_d = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      dmem_req_q     <= 1'b0;
      dmem_we_q      <= 1'b0;
      dmem_addr_q    <= '0;
      dmem_wdata_q   <= '0;
      rd_q           <= '0;
      cnt_q          <= '0;
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_rd_q        <= '0;
      wb_data_q      <= '0;
      misalign_q     <= 1'b0;
      bus_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      dmem_req_q     <= dmem_req_d;
      dmem_we_q      <= dmem_we_d;
      dmem_addr_q    <= dmem_addr_d;
      dmem_wdata_q   <= dmem_wdata_d;
      rd_q           <= rd_d;
      cnt_q          <= cnt_d;
      wb_valid_q     <= wb_valid_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_rd_q        <= wb_rd_d;
      wb_data_q      <= wb_data_d;
      misalign_q     <= misalign_d;
      bus_err_q      <= bus_err_d;
    end
  end

  assign ex_ready     = (state_q == IDLE);
  assign dmem_req     = dmem_req_q;
  assign dmem_we      = dmem_we_q;
  assign dmem_addr    = dmem_addr_q;
  assign dmem_wdata   = dmem_wdata_q;
  assign wb_valid     = wb_valid_q;
  assign wb_reg_write = wb_reg_write_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign misalign_err = misalign_q;
  assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage. A scoreboard queue holds the expected writeback pulses,
// and directed sequences cover the memory handshake, the timeout and reset.
module tb_mem_stage;

  localparam int TIMEOUT = 16;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_BR = 7'b1100011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready;
  logic [6:0]  ex_opcode;
  logic [31:0] ex_alu_result, ex_store_data;
  logic [4:0]  ex_rd;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        wb_valid, wb_reg_write, misalign_err, bus_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  mem_stage #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_opcode(ex_opcode),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .misalign_err(misalign_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        mis;
    logic        berr;
  } exp_t;

  typedef struct {
    logic [6:0]  op;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        exp_wb;
    logic        exp_mis;
  } vec_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad = 0;
  logic [4:0]  last_rd = '0;
  logic [31:0] last_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference model of the wb_rd/wb_data holding registers, advanced in completion order.
  task automatic push_exp(input logic rw, input logic upd_rd, input logic [4:0] rd,
                          input logic upd_data, input logic [31:0] data,
                          input logic mis, input logic berr);
    exp_t e;
    if (upd_rd) last_rd = rd;
    if (upd_data) last_data = data;
    e.rw = rw; e.rd = last_rd; e.data = last_data; e.mis = mis; e.berr = berr;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (wb_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_wb", 32'(wb_valid), 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          $display("wb: rd=%0d data=%h rw=%b mis=%b berr=%b", wb_rd, wb_data, wb_reg_write,
                   misalign_err, bus_err);
          check("wb_reg_write", 32'(wb_reg_write), 32'(e.rw));
          check("wb_rd", 32'(wb_rd), 32'(e.rd));
          check("wb_data", wb_data, e.data);
          check("misalign_err", 32'(misalign_err), 32'(e.mis));
          check("bus_err", 32'(bus_err), 32'(e.berr));
        end
      end else begin
        check("idle_pulses", 32'({wb_reg_write, misalign_err, bus_err}), 32'd0);
      end
    end
  end

  task automatic drive_ex(input logic [6:0] op, input logic [31:0] alu,
                          input logic [31:0] sd, input logic [4:0] rd);
    ex_valid = 1'b1; ex_opcode = op; ex_alu_result = alu; ex_store_data = sd; ex_rd = rd;
  endtask

  // Called #1 after a posedge; returns #1 after the completion edge.
  task automatic do_mem(input logic [6:0] op, input logic [31:0] addr, input logic [31:0] sd,
                        input logic [4:0] rd, input int waits, input logic [31:0] rdata,
                        input bit tmo);
    int req_cycles = 0;
    int stall_cycles = 0;
    if (tmo) push_exp(1'b0, 1'b0, rd, 1'b0, 32'd0, 1'b0, 1'b1);
    else if (op == OP_LW) push_exp(rd != 5'd0, 1'b1, rd, 1'b1, rdata, 1'b0, 1'b0);
    else push_exp(1'b0, 1'b1, rd, 1'b0, 32'd0, 1'b0, 1'b0);
    drive_ex(op, addr, sd, rd);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    for (int c = 0; c < 64; c++) begin
      if (!dmem_req) break;
      req_cycles++;
      if (!ex_ready) stall_cycles++;
      check("dmem_we", 32'(dmem_we), 32'(op == OP_SW));
      check("dmem_addr", dmem_addr, addr);
      if (op == OP_SW) check("dmem_wdata", dmem_wdata, sd);
      dmem_ready = (c == waits) && !tmo;
      dmem_rdata = dmem_ready ? rdata : $urandom;
      @(posedge clk); #1;
      dmem_ready = 1'b0;
    end
    check("req_cycles", 32'(req_cycles), tmo ? 32'(TIMEOUT) : 32'(waits + 1));
    check("stall_cycles", 32'(stall_cycles), tmo ? 32'(TIMEOUT) : 32'(waits + 1));
    check("ex_ready_after", 32'(ex_ready), 32'd1);
    $display("mem: op=%b addr=%h waits=%0d tmo=%0d req_cycles=%0d", op, addr, waits, tmo, req_cycles);
  endtask

  task automatic drain_check();
    @(negedge clk); #1;
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    vecs[0] = '{OP_I,     32'h0000_0005, 5'd3,  1'b1, 1'b0};
    vecs[1] = '{OP_R,     32'hA5A5_0000, 5'd31, 1'b1, 1'b0};
    vecs[2] = '{OP_AUIPC, 32'h1000_0004, 5'd0,  1'b1, 1'b0};
    vecs[3] = '{OP_BR,    32'h0000_0040, 5'd5,  1'b0, 1'b0};
    vecs[4] = '{7'b1101111, 32'h0000_0080, 5'd6, 1'b0, 1'b0};
    vecs[5] = '{OP_LW,    32'h0000_0102, 5'd4,  1'b1, 1'b1};
    vecs[6] = '{OP_SW,    32'h0000_0203, 5'd8,  1'b1, 1'b1};
    vecs[7] = '{OP_I,     32'h7FFF_FFFF, 5'd1,  1'b1, 1'b0};

    rst_n = 1'b0; ex_valid = 1'b0; ex_opcode = '0; ex_alu_result = '0; ex_store_data = '0;
    ex_rd = '0; dmem_ready = 1'b0; dmem_rdata = '0;
    #23;
    check("rst_ex_ready", 32'(ex_ready), 32'd1);
    check("rst_dmem_req", 32'(dmem_req), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_wb_rd", 32'(wb_rd), 32'd0);
    check("rst_dmem_addr", dmem_addr, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      if (vecs[i].exp_mis) push_exp(1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b1, 1'b0);
      else if (vecs[i].exp_wb) push_exp(vecs[i].rd != 5'd0, 1'b1, vecs[i].rd, 1'b1, vecs[i].alu, 1'b0, 1'b0);
      drive_ex(vecs[i].op, vecs[i].alu, 32'hFFFF_FFFF, vecs[i].rd);
      @(posedge clk); #1;
      ex_valid = 1'b0;
      @(negedge clk);
      $display("vec %0d: op=%b wb_valid=%b mis=%b", i, vecs[i].op, wb_valid, misalign_err);
      check("vec_wb_valid", 32'(wb_valid), 32'(vecs[i].exp_wb));
      check("vec_misalign", 32'(misalign_err), 32'(vecs[i].exp_mis));
      check("vec_no_req", 32'(dmem_req), 32'd0);
      check("vec_ex_ready", 32'(ex_ready), 32'd1);
      @(posedge clk); #1;
    end
    drain_check();

    // Back-to-back ALU instructions, one accepted per cycle.
    for (int k = 0; k < 3; k++) begin
      push_exp(1'b1, 1'b1, 5'(10 + k), 1'b1, 32'h100 + 32'(k), 1'b0, 1'b0);
      drive_ex(OP_I, 32'h100 + 32'(k), 32'd0, 5'(10 + k));
      @(posedge clk); #1;
    end
    ex_valid = 1'b0;
    drain_check();

    do_mem(OP_LW, 32'h0000_0100, 32'd0, 5'd7, 0, 32'hDEAD_BEEF, 1'b0);
    // Accept an ALU op in the cycle the load completion pulse is visible.
    push_exp(1'b1, 1'b1, 5'd2, 1'b1, 32'h0000_0042, 1'b0, 1'b0);
    drive_ex(OP_R, 32'h0000_0042, 32'd0, 5'd2);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    drain_check();

    do_mem(OP_SW, 32'h0000_0204, 32'h0000_1234, 5'd9, 3, 32'h0, 1'b0);
    drain_check();
    do_mem(OP_LW, 32'h0000_0300, 32'd0, 5'd12, 0, 32'h0, 1'b1);
    drain_check();
    do_mem(OP_LW, 32'h0000_0304, 32'd0, 5'd13, TIMEOUT - 1, 32'h1357_9BDF, 1'b0);
    drain_check();

    // Reset in the middle of an access: request drops at once, no writeback.
    drive_ex(OP_LW, 32'h0000_0500, 32'd0, 5'd14);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_req", 32'(dmem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_req_drop", 32'(dmem_req), 32'd0);
    check("rst_no_wb", 32'(wb_valid), 32'd0);
    check("rst_ex_ready2", 32'(ex_ready), 32'd1);
    last_rd = '0; last_data = '0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_mem(OP_LW, 32'h0000_0400, 32'd0, 5'd0, 0, 32'hCAFE_F00D, 1'b0);
    drain_check();
    repeat (3) @(posedge clk);
    #1;
    check("final_drain", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage RV32 pipeline, directly downstream of the execute ALU.
- Consumes the ALU result, store data and control for each instruction.
- Performs LW/SW against a variable-latency data memory; passes ALU/AUIPC results through.
- Presents a registered writeback bundle, which is also the MEM forwarding source (MEM_data) to the ALU.
- Stalls execute while a memory access is outstanding.

Parameters:
- TIMEOUT, 16, max cycles in ACCESS waiting for dmem_ready before abort (≥1).
- CNT_W, 5, width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ex_valid  in  1  execute presents an instruction.
- ex_ready  out  1  stage can accept; instruction transfers when ex_valid && ex_ready.
- ex_opcode  in  7  instruction opcode.
- ex_alu_result  in  32  ALU result; also the address for LW/SW.
- ex_store_data  in  32  forwarded rs2 value for SW.
- ex_rd  in  5  destination register.
- dmem_req  out  1  memory request, held until dmem_ready.
- dmem_we  out  1  1=store, 0=load.
- dmem_addr  out  32  word address (byte-addressed, aligned).
- dmem_wdata  out  32  store data.
- dmem_ready  in  1  memory completes request this cycle.
- dmem_rdata  in  32  load data, valid when dmem_ready.
- wb_valid  out  1  one-cycle pulse: instruction retired from MEM.
- wb_reg_write  out  1  one-cycle pulse: write wb_data to wb_rd.
- wb_rd  out  5  destination register.
- wb_data  out  32  writeback/forwarding value.
- misalign_err  out  1  one-cycle pulse: LW/SW with addr[1:0]≠0.
- bus_err  out  1  one-cycle pulse: access timed out.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - dmem_req, dmem_we, wb_valid, wb_reg_write, misalign_err and bus_err go to 0.
  - dmem_addr, dmem_wdata, wb_data, wb_rd go to 0; timeout counter goes to 0.
  - An access in progress is dropped: dmem_req deasserts immediately, with no writeback.
- FSM has two states: IDLE and ACCESS.
- ex_ready is 1 exactly when state=IDLE; it is combinational from state only.
- IDLE, accepting opcode 0110011, 0010011 or 0010111:
  - Next edge: wb_valid=1, wb_data=ex_alu_result, wb_rd=ex_rd, wb_reg_write=(ex_rd≠0).
  - Latency 1; state stays IDLE.
- IDLE, accepting LW (0000011) or SW (0100011) with ex_alu_result[1:0]=0:
  - Next edge: dmem_req=1, dmem_we=(SW), dmem_addr=ex_alu_result, dmem_wdata=ex_store_data.
  - Latch rd; counter=0; state→ACCESS.
- IDLE, accepting LW/SW with ex_alu_result[1:0]≠0:
  - No memory request.
  - Next edge: wb_valid=1, wb_reg_write=0, misalign_err=1; state stays IDLE.
- IDLE, accepting opcode 1100011 or any other opcode: consumed silently, wb_valid=0, no side effects.
- ACCESS:
  - dmem_req, dmem_we, dmem_addr and dmem_wdata are held stable.
  - Counter increments each cycle dmem_ready=0.
- dmem_ready=1 in any ACCESS cycle, including the first:
  - Next edge: dmem_req=0, wb_valid=1, wb_rd=latched rd, state→IDLE.
  - LW: wb_data=dmem_rdata, wb_reg_write=(rd≠0).
  - SW: wb_reg_write=0 and wb_data is unchanged.
- Minimum load latency is 2 edges from acceptance to wb_valid.
- Timeout: if counter reaches TIMEOUT−1 with dmem_ready=0:
  - Next edge: dmem_req=0, bus_err=1, wb_valid=1, wb_reg_write=0, state→IDLE.
  - If dmem_ready=1 in that same cycle, ready wins (normal completion, no bus_err).
- wb_valid, wb_reg_write, misalign_err and bus_err are single-cycle pulses; they are 0 in every cycle not listed above.
- wb_data and wb_rd hold their last value when not updated.
- dmem_ready while in IDLE is ignored.
- Back-to-back: an instruction accepted in the same cycle a completion pulse is generated is legal. In IDLE, a new instruction is accepted every cycle.

Test Plan:
- ADDI result: ex_valid with opcode 0010011, alu_result=0x0000_0005, rd=3 → one cycle later wb_valid=1, wb_reg_write=1, wb_rd=3, wb_data=5; ex_ready stays 1.
- Zero-wait LW: addr 0x100, rd=7, dmem_ready high on first req cycle with rdata=0xDEADBEEF → dmem_req high exactly 1 cycle; wb_data=0xDEADBEEF, wb_reg_write=1 on edge 2; ex_ready low 1 cycle.
- SW with 3 wait states: addr 0x204, store_data=0x1234 → dmem_we=1, addr and wdata stable for 4 cycles; then wb_valid=1, wb_reg_write=0; ex_ready low for 4 cycles.
- Misaligned LW at 0x102 → no dmem_req; misalign_err=1 and wb_valid=1 one cycle later; wb_reg_write=0.
- Timeout with TIMEOUT=16 and dmem_ready never asserted → dmem_req high exactly 16 cycles, then bus_err=1 and wb_valid=1, return to IDLE; repeat with ready asserted in cycle 16 → no bus_err, data written.
- rst_n pulsed low mid-ACCESS and LW with rd=0 → dmem_req drops asynchronously with no wb pulse; rd=0 load completes with wb_valid=1 and wb_reg_write=0.
